// File: rtl/flag_word_serializer_pkg.sv
// Shared flag package: the 96-bit top_flag_t word and the serializer state encoding.
package flag_word_serializer_pkg;

  localparam int FLAG_W = 96;

  typedef union packed {
    logic [2:0][31:0] words;
    logic [11:0][7:0] bytes;
  } top_flag_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } flag_ser_state_e;

endpackage

// File: rtl/flag_word_serializer.sv
// Splits one top_flag_t word into NUM_BEATS narrow beats with first/last markers.
module flag_word_serializer
  import flag_word_serializer_pkg::*;
#(
  parameter int BEAT_W    = 32,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  top_flag_t         in_flag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_first,
  output logic              out_last,
  output logic              busy
);

  localparam int NUM_BEATS = FLAG_W / BEAT_W;
  localparam int IDX_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

  flag_ser_state_e r_state;
  logic [IDX_W-1:0] r_idx;
  top_flag_t        r_hold;

  logic [NUM_BEATS-1:0][BEAT_W-1:0] w_beats;
  logic [IDX_W-1:0]                 w_slice;
  logic                             w_at_last;
  logic                             w_xfer;
  logic                             w_accept;

  assign w_beats   = r_hold;
  assign w_slice   = MSB_FIRST ? (LAST_IDX - r_idx) : r_idx;
  assign w_at_last = (r_idx == LAST_IDX);

  assign out_valid = (r_state == SEND);
  assign busy      = (r_state == SEND);
  // Driven from the holding register even when idle so out_data is never X.
  assign out_data  = w_beats[w_slice];
  assign out_first = out_valid && (r_idx == '0);
  assign out_last  = out_valid && w_at_last;

  assign w_xfer    = out_valid && out_ready;
  assign in_ready  = (r_state == IDLE) || (out_last && out_ready);
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_hold  <= in_flag;
            r_idx   <= '0;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_xfer) begin
            if (w_at_last) begin
              r_idx <= '0;
              // Taking the next word on the last beat keeps the stream bubble-free.
              if (w_accept) begin
                r_hold <= in_flag;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flag_word_serializer.sv
// Directed checks of flag_word_serializer: LSB/MSB-first 32-bit beats and 8-bit beats.
module tb_flag_word_serializer;
  import flag_word_serializer_pkg::*;

  localparam logic [95:0] W1 = 96'hAAAA_0003_BBBB_0002_CCCC_0001;
  localparam logic [95:0] W2 = 96'h1;
  localparam logic [95:0] W8 = 96'h0B0A_0908_0706_0504_0302_0100;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Group A: two 32-bit instances (LSB-first, MSB-first) sharing stimulus.
  logic        a_in_valid, a_out_ready;
  top_flag_t   a_in_flag;
  logic        l_in_ready, l_out_valid, l_out_first, l_out_last, l_busy;
  logic [31:0] l_out_data;
  logic        m_in_ready, m_out_valid, m_out_first, m_out_last, m_busy;
  logic [31:0] m_out_data;

  // Group B: 8-bit beats, LSB-first.
  logic        b_in_valid, b_out_ready;
  top_flag_t   b_in_flag;
  logic        b_in_ready, b_out_valid, b_out_first, b_out_last, b_busy;
  logic [7:0]  b_out_data;

  flag_word_serializer #(.BEAT_W(32), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(l_in_ready),
    .in_flag(a_in_flag), .out_valid(l_out_valid), .out_ready(a_out_ready),
    .out_data(l_out_data), .out_first(l_out_first), .out_last(l_out_last), .busy(l_busy)
  );

  flag_word_serializer #(.BEAT_W(32), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(m_in_ready),
    .in_flag(a_in_flag), .out_valid(m_out_valid), .out_ready(a_out_ready),
    .out_data(m_out_data), .out_first(m_out_first), .out_last(m_out_last), .busy(m_busy)
  );

  flag_word_serializer #(.BEAT_W(8), .MSB_FIRST(1'b0)) dut_b8 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_flag(b_in_flag), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_first(b_out_first), .out_last(b_out_last), .busy(b_busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic beat_a(input string tag, input logic [31:0] dl, input logic [31:0] dm,
                        input logic first, input logic last);
    $display("[%0t] %s: lsb=%h msb=%h first=%b last=%b", $time, tag, l_out_data, m_out_data,
             l_out_first, l_out_last);
    chk({tag, " lsb valid"}, 96'(l_out_valid), 96'(1'b1));
    chk({tag, " msb valid"}, 96'(m_out_valid), 96'(1'b1));
    chk({tag, " lsb data"},  96'(l_out_data),  96'(dl));
    chk({tag, " msb data"},  96'(m_out_data),  96'(dm));
    chk({tag, " lsb first"}, 96'(l_out_first), 96'(first));
    chk({tag, " msb first"}, 96'(m_out_first), 96'(first));
    chk({tag, " lsb last"},  96'(l_out_last),  96'(last));
    chk({tag, " msb last"},  96'(m_out_last),  96'(last));
  endtask

  task automatic idle_a(input string tag);
    $display("[%0t] %s: idle check", $time, tag);
    chk({tag, " lsb valid"}, 96'(l_out_valid), 96'(1'b0));
    chk({tag, " msb valid"}, 96'(m_out_valid), 96'(1'b0));
    chk({tag, " lsb busy"},  96'(l_busy),      96'(1'b0));
    chk({tag, " msb busy"},  96'(m_busy),      96'(1'b0));
    chk({tag, " lsb in_ready"}, 96'(l_in_ready), 96'(1'b1));
  endtask

  initial begin
    int exp_idx;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_in_flag = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_flag = '0;
    repeat (2) @(negedge clk);
    #1;
    idle_a("reset");
    chk("reset lsb data",  96'(l_out_data),  96'h0);
    chk("reset lsb first", 96'(l_out_first), 96'h0);
    chk("reset lsb last",  96'(l_out_last),  96'h0);
    chk("reset b8 ready",  96'(b_in_ready),  96'h1);
    rst_n = 1'b1;

    // Single word, both beat orders.
    @(negedge clk);
    a_in_valid = 1'b1; a_in_flag = W1;
    #1 chk("single accept ready", 96'(l_in_ready), 96'h1);
    @(negedge clk); a_in_valid = 1'b0;
    #1 beat_a("single b0", 32'hCCCC0001, 32'hAAAA0003, 1'b1, 1'b0);
    @(negedge clk);
    #1 beat_a("single b1", 32'hBBBB0002, 32'hBBBB0002, 1'b0, 1'b0);
    @(negedge clk);
    #1 beat_a("single b2", 32'hAAAA0003, 32'hCCCC0001, 1'b0, 1'b1);
    chk("single last in_ready", 96'(l_in_ready), 96'h1);
    @(negedge clk);
    #1 idle_a("single end");

    // Backpressure on beat 1, with in_flag churn and in_valid offered while stalled.
    a_in_valid = 1'b1; a_in_flag = W1;
    @(negedge clk); a_in_valid = 1'b0;
    #1 beat_a("bp b0", 32'hCCCC0001, 32'hAAAA0003, 1'b1, 1'b0);
    @(negedge clk);
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_flag = 96'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      #1 beat_a($sformatf("bp stall%0d", k), 32'hBBBB0002, 32'hBBBB0002, 1'b0, 1'b0);
      chk($sformatf("bp stall%0d in_ready", k), 96'(l_in_ready), 96'h0);
      @(negedge clk);
    end
    a_out_ready = 1'b1; a_in_valid = 1'b0;
    #1 beat_a("bp b1", 32'hBBBB0002, 32'hBBBB0002, 1'b0, 1'b0);
    @(negedge clk);
    #1 beat_a("bp b2", 32'hAAAA0003, 32'hCCCC0001, 1'b0, 1'b1);
    @(negedge clk);
    #1 idle_a("bp end");

    // Back-to-back: word2 offered during the last beat of word1.
    a_in_valid = 1'b1; a_in_flag = W1;
    @(negedge clk); a_in_valid = 1'b0;
    #1 beat_a("b2b w1b0", 32'hCCCC0001, 32'hAAAA0003, 1'b1, 1'b0);
    @(negedge clk);
    #1 beat_a("b2b w1b1", 32'hBBBB0002, 32'hBBBB0002, 1'b0, 1'b0);
    @(negedge clk);
    a_in_valid = 1'b1; a_in_flag = W2;
    #1 beat_a("b2b w1b2", 32'hAAAA0003, 32'hCCCC0001, 1'b0, 1'b1);
    chk("b2b lsb in_ready", 96'(l_in_ready), 96'h1);
    chk("b2b msb in_ready", 96'(m_in_ready), 96'h1);
    @(negedge clk); a_in_valid = 1'b0;
    #1 beat_a("b2b w2b0", 32'h00000001, 32'h00000000, 1'b1, 1'b0);
    @(negedge clk);
    #1 beat_a("b2b w2b1", 32'h00000000, 32'h00000000, 1'b0, 1'b0);
    @(negedge clk);
    #1 beat_a("b2b w2b2", 32'h00000000, 32'h00000001, 1'b0, 1'b1);
    @(negedge clk);
    #1 idle_a("b2b end");

    // Asynchronous reset in the middle of a word.
    a_in_valid = 1'b1; a_in_flag = W1;
    @(negedge clk); a_in_valid = 1'b0;
    #1 beat_a("rst b0", 32'hCCCC0001, 32'hAAAA0003, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 idle_a("rst async");
    @(negedge clk);
    rst_n = 1'b1; a_in_valid = 1'b1;
    @(negedge clk); a_in_valid = 1'b0;
    #1 beat_a("rst new b0", 32'hCCCC0001, 32'hAAAA0003, 1'b1, 1'b0);
    @(negedge clk);
    #1 beat_a("rst new b1", 32'hBBBB0002, 32'hBBBB0002, 1'b0, 1'b0);
    @(negedge clk);
    #1 beat_a("rst new b2", 32'hAAAA0003, 32'hCCCC0001, 1'b0, 1'b1);
    @(negedge clk);
    #1 idle_a("rst end");

    // 8-bit beats with a periodic stall; bounded cycle budget.
    b_in_valid = 1'b1; b_in_flag = W8;
    @(negedge clk); b_in_valid = 1'b0;
    exp_idx = 0;
    for (int c = 0; c < 40 && exp_idx < 12; c++) begin
      b_out_ready = (c % 4 != 2);
      #1;
      $display("[%0t] b8 cyc%0d: data=%h first=%b last=%b ready=%b", $time, c, b_out_data,
               b_out_first, b_out_last, b_out_ready);
      chk($sformatf("b8 c%0d valid", c), 96'(b_out_valid), 96'h1);
      chk($sformatf("b8 c%0d data", c),  96'(b_out_data),  96'(exp_idx));
      chk($sformatf("b8 c%0d first", c), 96'(b_out_first), 96'(exp_idx == 0));
      chk($sformatf("b8 c%0d last", c),  96'(b_out_last),  96'(exp_idx == 11));
      chk($sformatf("b8 c%0d in_ready", c), 96'(b_in_ready), 96'(exp_idx == 11 && b_out_ready));
      if (b_out_ready) exp_idx++;
      @(negedge clk);
    end
    b_out_ready = 1'b1;
    #1;
    chk("b8 beats sent", 96'(exp_idx), 96'd12);
    chk("b8 end valid", 96'(b_out_valid), 96'h0);
    chk("b8 end busy",  96'(b_busy),      96'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flag_word_serializer.md
Name: flag_word_serializer

Overview:
- Transmit side of the 96-bit top_flag_t flag word that is carried as a packed union in the shared package.
- Accepts one whole flag word on a valid/ready input and emits it as NUM_BEATS narrow beats on a valid/ready output. Each beat carries first/last markers.
- Sits between the flag producer and the narrow link. The matching deserializer at the far end rebuilds the word.

Parameters:
- BEAT_W, 32, width of one output beat in bits. Must divide 96; legal values are 8, 16, 32, 48 and 96.
- MSB_FIRST, 0, beat order. 0 sends bits [BEAT_W-1:0] first; 1 sends the top slice first.
- NUM_BEATS, 96/BEAT_W, derived localparam. Not overridable.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer offers in_flag.
- in_ready  output  1  serializer can take a word this cycle.
- in_flag  input  96  top_flag_t word, packed union viewed as [2:0][31:0] words or [11:0][7:0] bytes.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  link accepts the beat.
- out_data  output  BEAT_W  current beat.
- out_first  output  1  beat index 0 of the word.
- out_last  output  1  beat index NUM_BEATS-1 of the word.
- busy  output  1  a word is held and not fully sent.

Behaviour:
- Reset (async assert, sync release): state=IDLE, beat counter=0, holding register=0. Outputs out_valid=0, out_data=0, out_first=0, out_last=0, busy=0, in_ready=1.
- States:
  - IDLE: no word held.
  - SEND: a word is held; beat counter idx runs 0..NUM_BEATS-1.
- IDLE -> SEND when in_valid && in_ready. On that edge: the word is latched into the holding register, idx=0, out_valid=1.
- Latency: word accepted on edge N; beat 0 is visible after edge N, so out_valid=1 in the cycle following acceptance.
- In SEND:
  - A beat transfers when out_valid && out_ready.
  - On a transfer with idx<NUM_BEATS-1: idx increments and the next slice is presented.
- Last-beat transfer:
  - If in_valid is also high, the new word is latched and SEND restarts at idx=0. This gives a back-to-back stream with no bubble.
  - Otherwise the block returns to IDLE with out_valid=0.
- in_ready = (state==IDLE) || (state==SEND && out_last && out_ready). This is a combinational path from out_ready to in_ready and is allowed.
- Beat selection: slice index s = MSB_FIRST ? NUM_BEATS-1-idx : idx. out_data = hold[s*BEAT_W +: BEAT_W].
- out_first = out_valid && idx==0. out_last = out_valid && idx==NUM_BEATS-1. busy = (state==SEND).
- Stall: while out_valid && !out_ready, out_data, out_first, out_last and idx hold stable. out_valid never drops without a transfer.
- NUM_BEATS=1 (BEAT_W=96): out_first and out_last are both high on the single beat. The block behaves as a one-deep registered pipe.
- Holding register is loaded only on acceptance. Changes on in_flag at other times are ignored.
- Reset mid-word: the held word is discarded and the next output is beat 0 of a freshly accepted word. No partial-word continuation.
- Counter width: $clog2(NUM_BEATS), minimum 1 bit. idx never exceeds NUM_BEATS-1.
- No X propagation: out_data is driven from the holding register even when out_valid=0.

Decomposition:
- Shared package (existing flag package) holds:
  - FLAG_W=96.
  - The top_flag_t packed union: words view [2:0][31:0] and bytes view [11:0][7:0].
  - State enum flag_ser_state_e {IDLE, SEND}.
- No sub-module needed; beat select is a single indexed part-select.
- The matching flag_word_deserializer reuses the same package and markers.

Test Plan:
- Reset then single word: in_flag=96'hAAAA_0003_BBBB_0002_CCCC_0001, BEAT_W=32, MSB_FIRST=0, out_ready=1.
  -> beats 0xCCCC0001 (first), 0xBBBB0002, 0xAAAA0003 (last) on three consecutive cycles after acceptance, then out_valid=0.
- Same word with MSB_FIRST=1 -> beat order 0xAAAA0003, 0xBBBB0002, 0xCCCC0001; out_first and out_last on the first and third beats.
- Backpressure: out_ready low for 4 cycles during beat 1 -> out_data stays 0xBBBB0002, idx unchanged, in_ready=0 throughout, no beat lost or duplicated.
- Back-to-back: in_valid held with word2=96'h1 offered during the last beat of word1 -> in_ready=1 on that cycle; word2 beat 0 (0x00000001, first) follows immediately with no idle cycle.
- Async reset asserted mid-word after beat 0 -> out_valid=0, busy=0, in_ready=1 immediately; the next accepted word starts at beat 0.
- BEAT_W=8: word 96'h0B0A_0908_0706_0504_0302_0100 -> twelve beats 0x00..0x0B; out_first only on 0x00, out_last only on 0x0B.
